// File: rtl/psram_burst_model.sv
// Behavioural PSRAM: latency-counted read/write bursts with byte lanes and
// either continuous or aligned wrapping address sequencing.
module psram_burst_model #(
    parameter int D_WIDTH   = 16,
    parameter int A_WIDTH   = 16,
    parameter int DEPTH     = 64,
    parameter int LATENCY   = 3,
    parameter int BURST_LEN = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [A_WIDTH-1:0] addr,
    input  logic               adv_L,
    input  logic               ce_L,
    input  logic               oe_L,
    input  logic               we_L,
    input  logic               ub_L,
    input  logic               lb_L,
    output logic               mem_wait,
    inout  wire  [D_WIDTH-1:0] data
);
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int HALF = D_WIDTH / 2;
    // Bits under the mask advance and wrap; bits outside it hold the burst block.
    localparam logic [AW-1:0] WRAP_MASK = (BURST_LEN == 0) ? {AW{1'b1}} : AW'(BURST_LEN - 1);
    localparam logic [3:0]    LAT_LOAD  = 4'(LATENCY - 1);

    // state   | meaning
    // IDLE    | no access; WAIT_RD/WAIT_WR count latency; RD_DATA/WR_DATA transfer beats
    typedef enum logic [2:0] {IDLE, WAIT_RD, WAIT_WR, RD_DATA, WR_DATA} state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      cur_q, cur_d, cur_inc;
    logic [3:0]         cnt_q, cnt_d;
    logic               wr_en;
    logic [D_WIDTH-1:0] rd_word;
    logic [D_WIDTH-1:0] mem [DEPTH] = '{default: '0};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cur_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        cur_inc = (cur_q & ~WRAP_MASK) | ((cur_q + 1'b1) & WRAP_MASK);
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        if (ce_L) begin
            state_d = IDLE;
        end else if (!adv_L) begin
            cur_d   = AW'(addr);
            cnt_d   = LAT_LOAD;
            state_d = we_L ? WAIT_RD : WAIT_WR;
        end else begin
            case (state_q)
                WAIT_RD: begin
                    if (cnt_q == '0) state_d = RD_DATA;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                WAIT_WR: begin
                    if (cnt_q == '0) state_d = WR_DATA;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                RD_DATA: cur_d = cur_inc;
                WR_DATA: begin
                    wr_en = 1'b1;
                    cur_d = cur_inc;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Memory has no reset so contents survive a reset mid-burst.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (!ub_L) mem[cur_q][D_WIDTH-1:HALF] <= data[D_WIDTH-1:HALF];
            if (!lb_L) mem[cur_q][HALF-1:0]       <= data[HALF-1:0];
        end
    end

    always_comb begin
        rd_word = mem[cur_q];
        if (ub_L) rd_word[D_WIDTH-1:HALF] = '0;
        if (lb_L) rd_word[HALF-1:0]       = '0;
    end

    assign data     = (state_q == RD_DATA && !oe_L) ? rd_word : 'z;
    assign mem_wait = (state_q == WAIT_RD) || (state_q == WAIT_WR);

endmodule
